gsp_arbiter: RTL and testbench

GSP_ARBITER -- requirements
Module: gsp_arbiter

---
 rtl/gsp_pkg.sv | 16 +
 rtl/gsp_arbiter.sv | 151 +++++++++++++++
 tb/tb_gsp_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gsp_pkg.sv
// gsp_pkg: shared definitions for the GSP unit arbiter.
//   GSP_NUM_BEATS  - default accepted beats per transaction (8 load + 15 unload)
//   GSP_IDLE_LIMIT - default owner-idle cycles before the transaction is aborted
//   gsp_state_e    - arbiter FSM state encoding
package gsp_pkg;

    localparam int GSP_NUM_BEATS  = 23;
    localparam int GSP_IDLE_LIMIT = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } gsp_state_e;

endpackage

// File: rtl/gsp_arbiter.sv
// gsp_arbiter: two-requester arbiter in front of a single shared GSP unit.
// A requester owns the unit for a whole NUM_BEATS transaction; ties go to
// the requester that did not own the unit last. An owner that stalls for
// IDLE_LIMIT+1 cycles is aborted through a one-cycle FLUSH that resets the unit.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req0/1, start0/1, a0/b0/a1/b1  requester side
//   gnt0/1, result0/1, wait_req0/1 requester side responses
//   u_start, u_a, u_b, u_rst    unit side drive
//   u_result, u_wait_req        unit side responses
//   txn_done, timeout           one-cycle completion / abort pulses
module gsp_arbiter
    import gsp_pkg::*;
#(
    parameter int NUM_BEATS  = GSP_NUM_BEATS,
    parameter int IDLE_LIMIT = GSP_IDLE_LIMIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       start0,
    input  logic       start1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] result0,
    output logic [7:0] result1,
    output logic       wait_req0,
    output logic       wait_req1,
    output logic       u_start,
    output logic [7:0] u_a,
    output logic [7:0] u_b,
    input  logic [7:0] u_result,
    input  logic       u_wait_req,
    output logic       u_rst,
    output logic       txn_done,
    output logic       timeout
);

    localparam int            BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);
    localparam logic [7:0]    IDLE_MAX  = 8'(IDLE_LIMIT);

    gsp_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [7:0]    idle_q, idle_d;

    // Gated by rst_n so an in-flight beat cannot complete or leak to the
    // unit during the reset cycle itself.
    logic busy, own_start, accept, final_beat;

    assign busy       = (state_q == ST_BUSY) && rst_n;
    assign own_start  = owner_q ? start1 : start0;
    assign accept     = busy && own_start && !u_wait_req;
    assign final_beat = accept && (beat_q == LAST_BEAT);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            beat_q       <= '0;
            idle_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
            idle_q       <= idle_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_d       = beat_q;
        idle_d       = idle_q;
        unique case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                idle_d = '0;
                if (req0 || req1) begin
                    state_d = ST_BUSY;
                    // Tie: alternate away from the previous owner.
                    owner_d = (req0 && req1) ? ~last_owner_q : req1;
                end
            end
            ST_BUSY: begin
                if (accept)
                    beat_d = final_beat ? '0 : beat_q + BW'(1);
                // A unit stall is not the owner's fault, so it does not age.
                if (accept || u_wait_req)
                    idle_d = '0;
                else if (idle_q != IDLE_MAX)
                    idle_d = idle_q + 8'd1;
                // Completion beats the idle abort when both land together.
                if (final_beat) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end else if (idle_q == IDLE_MAX) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d      = ST_IDLE;
                beat_d       = '0;
                idle_d       = '0;
                last_owner_d = owner_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        gnt0      = (state_q == ST_BUSY) && !owner_q;
        gnt1      = (state_q == ST_BUSY) &&  owner_q;
        u_start   = 1'b0;
        u_a       = 8'd0;
        u_b       = 8'd0;
        result0   = 8'd0;
        result1   = 8'd0;
        wait_req0 = 1'b1;
        wait_req1 = 1'b1;
        if (busy) begin
            u_start = own_start;
            u_a     = owner_q ? a1 : a0;
            u_b     = owner_q ? b1 : b0;
            if (owner_q) begin
                result1   = u_result;
                wait_req1 = u_wait_req;
            end else begin
                result0   = u_result;
                wait_req0 = u_wait_req;
            end
        end
        u_rst    = !rst_n || (state_q == ST_FLUSH);
        txn_done = final_beat;
        timeout  = rst_n && (state_q == ST_FLUSH);
    end

endmodule

// File: tb/tb_gsp_arbiter.sv
// tb_gsp_arbiter: directed scenarios with literal expectations plus a
// randomized phase; a transaction-level model checks every output each cycle.
module tb_gsp_arbiter;

    localparam int NB  = 23;
    localparam int LIM = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 0, req1 = 0, start0 = 0, start1 = 0;
    logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic [7:0] u_result = 0;
    logic       u_wait_req = 0;
    logic       gnt0, gnt1, wait_req0, wait_req1, u_start, u_rst, txn_done, timeout;
    logic [7:0] result0, result1, u_a, u_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gsp_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .start0(start0), .start1(start1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .result0(result0), .result1(result1),
        .wait_req0(wait_req0), .wait_req1(wait_req1),
        .u_start(u_start), .u_a(u_a), .u_b(u_b),
        .u_result(u_result), .u_wait_req(u_wait_req), .u_rst(u_rst),
        .txn_done(txn_done), .timeout(timeout)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- transaction-level model ----------------
    // owner -1 : nobody holds the unit; flush : current cycle is the abort cycle
    int m_owner = -1;
    bit m_flush = 0;
    int m_beats = 0;   // beats accepted so far in this transaction
    int m_quiet = 0;   // consecutive cycles the owner made no progress
    int m_last  = 1;

    always @(negedge clk) begin : cmp
        bit busy, ost, acc, fin, both;
        busy = rst_n && (m_owner >= 0) && !m_flush;
        ost  = (m_owner == 1) ? start1 : start0;
        acc  = busy && ost && !u_wait_req;
        fin  = acc && (m_beats == NB - 1);

        chk("gnt0", gnt0, (m_owner == 0) && !m_flush);
        chk("gnt1", gnt1, (m_owner == 1) && !m_flush);
        chk("u_start", u_start, busy && ost);
        chk("u_a", u_a, !busy ? 8'd0 : (m_owner == 1) ? a1 : a0);
        chk("u_b", u_b, !busy ? 8'd0 : (m_owner == 1) ? b1 : b0);
        chk("result0", result0, (busy && m_owner == 0) ? u_result : 8'd0);
        chk("result1", result1, (busy && m_owner == 1) ? u_result : 8'd0);
        chk("wait_req0", wait_req0, (busy && m_owner == 0) ? u_wait_req : 1'b1);
        chk("wait_req1", wait_req1, (busy && m_owner == 1) ? u_wait_req : 1'b1);
        chk("u_rst", u_rst, !rst_n || m_flush);
        chk("txn_done", txn_done, fin);
        chk("timeout", timeout, rst_n && m_flush);

        // advance to the next cycle
        if (!rst_n) begin
            m_owner = -1; m_flush = 0; m_beats = 0; m_quiet = 0; m_last = 1;
        end else if (m_flush) begin
            m_last = m_owner; m_owner = -1; m_flush = 0; m_beats = 0; m_quiet = 0;
        end else if (m_owner < 0) begin
            both = req0 && req1;
            if (req0 || req1) begin
                m_owner = both ? 1 - m_last : (req1 ? 1 : 0);
                m_beats = 0;
                m_quiet = 0;
            end
        end else begin
            if (fin) begin
                m_last = m_owner; m_owner = -1; m_beats = 0; m_quiet = 0;
            end else begin
                if (m_quiet == LIM) m_flush = 1;
                if (acc) m_beats++;
                if (acc || u_wait_req) m_quiet = 0;
                else if (m_quiet < LIM) m_quiet++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the owner's start until txn_done; returns cycles driven, -1 on bound.
    task automatic run_txn(input int who, output int beats);
        beats = -1;
        for (int i = 1; i <= 200; i++) begin
            if (who == 0) begin start0 = 1; a0 = 8'($urandom); b0 = 8'($urandom); end
            else          begin start1 = 1; a1 = 8'($urandom); b1 = 8'($urandom); end
            u_wait_req = 0;
            u_result   = 8'($urandom);
            #1;
            if (txn_done) beats = i;
            tick();
            if (beats >= 0) break;
        end
        start0 = 0;
        start1 = 0;
    endtask

    initial begin
        int r, got, acc, stall, cyc;
        repeat (3) tick();
        chk("reset_gnt0", gnt0, 0);
        chk("reset_wait_req0", wait_req0, 1);
        chk("reset_u_rst", u_rst, 1);

        // single requester, full transaction
        rst_n = 1; req0 = 1;
        tick();
        chk("s1_gnt0_next_cycle", gnt0, 1);
        req0 = 0;
        run_txn(0, r);
        chk("s1_done_on_beat", r, NB);
        chk("s1_gnt0_released", gnt0, 0);

        // simultaneous requests after reset: 0 first, then 1 two cycles later
        rst_n = 0; tick();
        rst_n = 1; req0 = 1; req1 = 1;
        tick();
        chk("s2_gnt0_first", gnt0, 1);
        chk("s2_gnt1_not", gnt1, 0);
        run_txn(0, r);
        chk("s2_txn0_beats", r, NB);
        got = -1;
        for (int k = 1; k <= 5; k++) begin
            if (gnt1) begin got = k; break; end
            tick();
        end
        chk("s2_gnt1_delay", got, 2);
        req0 = 0; req1 = 0;
        run_txn(1, r);
        chk("s2_txn1_beats", r, NB);

        // unit stall of 5 cycles at beat 8
        req0 = 1; tick(); req0 = 0;
        acc = 0; stall = 0; cyc = 0; got = -1;
        for (int i = 0; i < 100 && got < 0; i++) begin
            start0 = 1; a0 = 8'($urandom);
            u_wait_req = (acc == 7 && stall < 5);
            #1;
            if (u_wait_req) begin
                stall++;
                chk("s3_stall_passthru", wait_req0, 1);
            end else begin
                acc++;
                if (txn_done) got = acc;
            end
            cyc++;
            tick();
        end
        start0 = 0; u_wait_req = 0;
        chk("s3_done_accepted", got, NB);
        chk("s3_cycles", cyc, NB + 5);

        // owner goes quiet after beat 10 -> abort
        req0 = 1; tick(); req0 = 0;
        for (int i = 0; i < 10; i++) begin start0 = 1; tick(); end
        start0 = 0; req1 = 1;
        got = -1;
        for (int n = 1; n <= 300; n++) begin
            #1;
            if (timeout) begin
                got = n;
                chk("s4_flush_u_rst", u_rst, 1);
                chk("s4_flush_gnt0", gnt0, 0);
                break;
            end
            tick();
        end
        chk("s4_timeout_cycle", got, LIM + 2);
        tick();
        chk("s4_timeout_single", timeout, 0);
        tick();
        chk("s4_gnt1_after_abort", gnt1, 1);
        req1 = 0;
        run_txn(1, r);
        chk("s4_txn1_beats", r, NB);

        // reset at beat 12
        req0 = 1; tick(); req0 = 0;
        for (int i = 0; i < 11; i++) begin start0 = 1; tick(); end
        rst_n = 0;
        #1;
        chk("s5_rst_no_done", txn_done, 0);
        chk("s5_rst_no_timeout", timeout, 0);
        chk("s5_rst_u_rst", u_rst, 1);
        tick();
        start0 = 0;
        chk("s5_gnt0_low", gnt0, 0);
        rst_n = 1; req0 = 1;
        tick();
        req0 = 0;
        run_txn(0, r);
        chk("s5_full_after_reset", r, NB);

        // non-owner noise during owner 1 transaction
        req1 = 1; tick(); req1 = 0;
        for (int i = 0; i < 6; i++) begin
            start1 = 1; a1 = 8'(i + 1);
            start0 = i[0]; a0 = 8'hFF;
            #1;
            chk("s6_u_a_owner", u_a, i + 1);
            chk("s6_nonowner_wait", wait_req0, 1);
            chk("s6_nonowner_result", result0, 0);
            tick();
        end
        start0 = 0;
        run_txn(1, r);
        chk("s6_txn1_beats", r, NB - 6);

        // randomized traffic; one segment with starts suppressed to force aborts
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 500; c++) begin
                rst_n      = ($urandom_range(0, 299) != 0);
                req0       = ($urandom_range(0, 2) == 0);
                req1       = ($urandom_range(0, 2) == 0);
                start0     = (seg != 3) && ($urandom_range(0, 9) < 7);
                start1     = (seg != 3) && ($urandom_range(0, 9) < 7);
                a0 = 8'($urandom); b0 = 8'($urandom);
                a1 = 8'($urandom); b1 = 8'($urandom);
                u_result   = 8'($urandom);
                u_wait_req = ($urandom_range(0, 4) == 0);
                tick();
            end
        end
        rst_n = 0; req0 = 0; req1 = 0; start0 = 0; start1 = 0; u_wait_req = 0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
